// File: rtl/qpsk_mapper_upsampler.sv
// qpsk_mapper_upsampler
//   Packs a serial bit stream into QPSK symbols and emits them as zero-stuffed
//   impulses, one symbol slot every UPS_FACTOR cycles, ready for I/Q
//   pulse-shaping filters.
//
// Parameters
//   UPS_FACTOR : output samples per symbol, legal range 2..16 (default 8)
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bit_in     : serial payload bit
//   bit_valid  : bit_in qualifier
//   bit_ready  : a bit is accepted when bit_valid && bit_ready
//   usp_i      : upsampled I sample (+1 = 2'b01, -1 = 2'b11, 0 = 2'b00)
//   usp_q      : upsampled Q sample
//   sym_strobe : usp_i/usp_q carry a symbol impulse this cycle
//   underflow  : one-cycle pulse when a symbol slot found no symbol held
//
// Optional feature
//   QPSK_SCRAMBLER_EN : when defined, each accepted bit is XORed with a PRBS-7
//   (x^7 + x^6 + 1, seed 7'h7F) that advances once per accepted bit.

module qpsk_mapper_upsampler #(
  parameter int unsigned UPS_FACTOR = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic signed [1:0] usp_i,
  output logic signed [1:0] usp_q,
  output logic              sym_strobe,
  output logic              underflow
);

  localparam int unsigned PH_W = (UPS_FACTOR > 2) ? $clog2(UPS_FACTOR) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(UPS_FACTOR - 1);

  localparam logic signed [1:0] SYM_POS  = 2'sb01;
  localparam logic signed [1:0] SYM_NEG  = 2'sb11;
  localparam logic signed [1:0] SYM_ZERO = 2'sb00;

  // State registers
  logic [PH_W-1:0] phase_q, phase_d;
  logic            pair_q, pair_d;        // 1: I bit captured, waiting for Q
  logic            i_bit_q, i_bit_d;      // captured I bit of the pending pair
  logic            sym_full_q, sym_full_d;
  logic            sym_i_q, sym_i_d;      // held symbol, raw bits
  logic            sym_q_q, sym_q_d;

  // Output next values
  logic signed [1:0] usp_i_d, usp_q_d;
  logic              sym_strobe_d, underflow_d;

  logic accept_c;
  logic slot_c;
  logic bit_eff_c;

  assign accept_c  = bit_valid & ~sym_full_q;
  assign slot_c    = (phase_q == '0);
  assign bit_ready = ~sym_full_q;

`ifdef QPSK_SCRAMBLER_EN
  // PRBS-7 whitening: tap bits 7 and 6, shifted once per accepted bit
  logic [6:0] prbs_q, prbs_d;
  logic       prbs_bit_c;

  assign prbs_bit_c = prbs_q[6] ^ prbs_q[5];
  assign bit_eff_c  = bit_in ^ prbs_bit_c;
  assign prbs_d     = accept_c ? {prbs_q[5:0], prbs_bit_c} : prbs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prbs_q <= 7'h7F;
    end else begin
      prbs_q <= prbs_d;
    end
  end
`else
  assign bit_eff_c = bit_in;
`endif

  // Next-state and output logic
  always_comb begin
    phase_d      = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    pair_d       = pair_q;
    i_bit_d      = i_bit_q;
    sym_full_d   = sym_full_q;
    sym_i_d      = sym_i_q;
    sym_q_d      = sym_q_q;
    usp_i_d      = SYM_ZERO;
    usp_q_d      = SYM_ZERO;
    sym_strobe_d = 1'b0;
    underflow_d  = 1'b0;

    // Symbol slot: emit the held symbol or flag starvation
    if (slot_c) begin
      if (sym_full_q) begin
        usp_i_d      = sym_i_q ? SYM_NEG : SYM_POS;
        usp_q_d      = sym_q_q ? SYM_NEG : SYM_POS;
        sym_strobe_d = 1'b1;
        sym_full_d   = 1'b0;
      end else begin
        underflow_d  = 1'b1;
      end
    end

    // Bit capture; accept_c implies the holding register is empty, so this
    // never collides with the emit branch above.
    if (accept_c) begin
      if (!pair_q) begin
        i_bit_d = bit_eff_c;
        pair_d  = 1'b1;
      end else begin
        sym_i_d    = i_bit_q;
        sym_q_d    = bit_eff_c;
        sym_full_d = 1'b1;
        pair_d     = 1'b0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= '0;
      pair_q     <= 1'b0;
      i_bit_q    <= 1'b0;
      sym_full_q <= 1'b0;
      sym_i_q    <= 1'b0;
      sym_q_q    <= 1'b0;
      usp_i      <= SYM_ZERO;
      usp_q      <= SYM_ZERO;
      sym_strobe <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      pair_q     <= pair_d;
      i_bit_q    <= i_bit_d;
      sym_full_q <= sym_full_d;
      sym_i_q    <= sym_i_d;
      sym_q_q    <= sym_q_d;
      usp_i      <= usp_i_d;
      usp_q      <= usp_q_d;
      sym_strobe <= sym_strobe_d;
      underflow  <= underflow_d;
    end
  end

endmodule
